fetch_addr_unit: RTL and testbench
==================================

# fetch_addr_unit

Program-counter, stack-pointer and instruction-register stage of the multicycle CPU datapath. It consumes the controller's sequencing strobes (IRWrite, PCWrite, PCWriteCond, PCSrc, SPWrite, PCMUX, IorD, MemRead, MemWrite). It drives the unified-memory address and feeds opcode/func back to the controller. It holds PC, SP, IR, MDR and ALUOut, and guards the stack region.

## Interface
- DATA_W, 16, datapath and address width
- PC_INIT, 16'h0000, PC reset value
- STACK_BASE, 16'hFFFF, SP reset value and highest legal SP
- STACK_LIMIT, 16'hFF00, lowest legal SP
---
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ir_write, pc_write, pc_write_cond, sp_write, pc_mux, mem_read, mem_write  in  1 each  controller strobes
- pc_src  in  2  PC next-value select
- iord  in  2  memory address select
- alu_result  in  DATA_W  combinational ALU output
- alu_zero  in  1  ALU zero flag
- store_data  in  DATA_W  register-file B port (SW/PUSH data)
- mem_rdata  in  DATA_W  combinational memory read data
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  = store_data
- mem_we, mem_re  out  1  = mem_write (gated), mem_read
- alu_a_base  out  DATA_W  pc_mux ? sp : pc
- opcode  out  4  ir[15:12]
- func  out  4  ir[3:0]
- pc, sp, ir, mdr, alu_out  out  DATA_W  architectural/holding registers
- stack_err  out  1  sticky illegal-SP flag
- instr_cnt  out  16  fetched-instruction counter

## Operation
- Instruction word: [15:12] opcode, [11:8] ra, [7:4] rb, [3:0] func/imm; jump target ir[11:0].
- mem_addr mux:
  - iord=0 → pc_mux ? sp : pc (fetch, or POP read at SP)
  - iord=1 → sp (PUSH write)
  - iord=2 or 3 → alu_out (LW/SW)
- PC load condition: pc_write | (pc_write_cond & alu_zero).
- PC next value by pc_src:
  - 0 → alu_result
  - 1 → alu_out (branch target)
  - 2 → {pc[15:12], ir[11:0]}
  - 3 → PC holds
- pc_mux=1 blocks all PC loads, regardless of pc_write and pc_write_cond.
- SP: on sp_write, sp ← alu_result only if STACK_LIMIT ≤ alu_result ≤ STACK_BASE (unsigned). Otherwise sp holds and stack_err sets.
- stack_err is sticky until rst.
- mem_we = mem_write & ~stack_err: no memory writes once the stack is corrupt.
- IR: ir ← mem_rdata on ir_write.
- instr_cnt increments on each ir_write and wraps FFFF→0000.
- MDR: mdr ← mem_rdata on any cycle with mem_read=1; holds otherwise.
- ALUOut: alu_out ← alu_result every cycle, unconditionally.

## Timing
- All registers update on posedge clk.
- mem_addr, alu_a_base, opcode, func, mem_we, mem_re and mem_wdata are combinational from registers/inputs. Memory read is same-cycle.
- rst asserted, asynchronously:
  - pc=PC_INIT, sp=STACK_BASE
  - ir=0, mdr=0, alu_out=0
  - stack_err=0, instr_cnt=0
  - hence opcode=0, func=0
- rst mid-instruction discards all partial state. The first cycle after release fetches at PC_INIT.
- IF cycle with ir_write & pc_write together: IR captures the word at the old PC (address sampled before the edge); PC takes alu_result.
- pc_write and pc_write_cond together: load occurs once with the pc_src value; alu_zero is irrelevant.
- pc_write_cond with alu_zero=0: PC holds.
- sp_write on the same edge as an illegal value: stack_err is visible the next cycle. A mem_write in that same cycle is still performed.
- No internal latency beyond one register stage. ALUOut always reflects the previous cycle's alu_result.

## Test plan
- Reset then fetch:
  - Stimulus: rst pulse; mem_rdata=16'h1A05; ir_write=1, pc_write=1, pc_src=0, alu_result=1.
  - Response: before the edge mem_addr=0000; after the edge ir=1A05, opcode=1, func=5, pc=0001, instr_cnt=1.
- Jump:
  - Stimulus: pc=3004, ir=C123, pc_write=1, pc_src=2.
  - Response: pc=3123.
  - Stimulus: pc_src=3.
  - Response: pc holds.
- Conditional branch:
  - Stimulus: alu_out=0040 latched, pc_write_cond=1, pc_src=1, alu_zero=0.
  - Response: pc unchanged.
  - Stimulus: repeat with alu_zero=1.
  - Response: pc=0040.
- Push/pop:
  - Stimulus: pc_mux=1, sp_write=1, alu_result=FFFE.
  - Response: sp=FFFE, pc unchanged, alu_a_base=FFFE.
  - Stimulus: iord=1, mem_write=1.
  - Response: mem_addr=FFFE, mem_we=1.
  - Stimulus: iord=0, pc_mux=1.
  - Response: mem_addr=sp.
- Stack guard:
  - Stimulus: sp_write with alu_result=FEFF.
  - Response: sp holds, stack_err=1 next cycle; subsequent mem_write gives mem_we=0.
  - Stimulus: rst.
  - Response: stack_err=0, sp=FFFF.
- Async reset mid-LW:
  - Stimulus: assert rst between clock edges while iord=2.
  - Response: pc=0000, ir=0, mdr=0 immediately, without waiting for a clock edge.
  - Stimulus: instr_cnt=FFFF, then ir_write.
  - Response: instr_cnt wraps to 0000.

Source files
------------

// File: rtl/fetch_addr_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_addr_unit
// Description : PC / SP / IR / MDR / ALUOut holding registers of the
//               multicycle CPU datapath. Selects the unified-memory address,
//               feeds opcode/func back to the controller, and guards the
//               stack region with a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_addr_unit #(
    parameter int              DATA_W      = 16,
    parameter logic [DATA_W-1:0] PC_INIT     = 16'h0000,
    parameter logic [DATA_W-1:0] STACK_BASE  = 16'hFFFF,
    parameter logic [DATA_W-1:0] STACK_LIMIT = 16'hFF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ir_write,
    input  logic              pc_write,
    input  logic              pc_write_cond,
    input  logic              sp_write,
    input  logic              pc_mux,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        pc_src,
    input  logic [1:0]        iord,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] alu_a_base,
    output logic [3:0]        opcode,
    output logic [3:0]        func,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] sp,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] alu_out,
    output logic              stack_err,
    output logic [15:0]       instr_cnt
);

    localparam logic [1:0] c_SRC_ALU  = 2'd0;
    localparam logic [1:0] c_SRC_AOUT = 2'd1;
    localparam logic [1:0] c_SRC_JUMP = 2'd2;

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_sp;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_alu_out;
    logic              r_stack_err;
    logic [15:0]       r_instr_cnt;

    logic              w_pc_load;
    logic [DATA_W-1:0] w_pc_next;
    logic              w_sp_legal;
    logic [DATA_W-1:0] w_base;

    // A stack access (pc_mux) never moves the PC, even if the controller
    // also raises pc_write or pc_write_cond.
    assign w_pc_load  = ~pc_mux & (pc_write | (pc_write_cond & alu_zero));
    assign w_sp_legal = (alu_result >= STACK_LIMIT) && (alu_result <= STACK_BASE);
    assign w_base     = pc_mux ? r_sp : r_pc;

    // Next-PC select; code 3 holds the current value.
    always_comb begin
        w_pc_next = r_pc;
        case (pc_src)
            c_SRC_ALU:  w_pc_next = alu_result;
            c_SRC_AOUT: w_pc_next = r_alu_out;
            c_SRC_JUMP: w_pc_next = {r_pc[DATA_W-1:12], r_ir[11:0]};
            default:    w_pc_next = r_pc;
        endcase
    end

    // Memory address select: fetch/POP, PUSH at SP, or LW/SW at ALUOut.
    always_comb begin
        mem_addr = w_base;
        case (iord)
            2'd0:    mem_addr = w_base;
            2'd1:    mem_addr = r_sp;
            default: mem_addr = r_alu_out;
        endcase
    end

    // Program counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_pc <= PC_INIT;
        else if (w_pc_load) r_pc <= w_pc_next;
    end

    // Stack pointer with range guard; an out-of-range write sets a sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp        <= STACK_BASE;
            r_stack_err <= 1'b0;
        end else if (sp_write) begin
            if (w_sp_legal) r_sp        <= alu_result;
            else            r_stack_err <= 1'b1;
        end
    end

    // Instruction register and fetched-instruction counter (wraps naturally).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir        <= '0;
            r_instr_cnt <= '0;
        end else if (ir_write) begin
            r_ir        <= mem_rdata;
            r_instr_cnt <= r_instr_cnt + 16'd1;
        end
    end

    // Memory data register captures every read cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_mdr <= '0;
        else if (mem_read) r_mdr <= mem_rdata;
    end

    // ALUOut always holds the previous cycle's ALU result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_alu_out <= '0;
        else     r_alu_out <= alu_result;
    end

    assign mem_wdata  = store_data;
    assign mem_we     = mem_write & ~r_stack_err;
    assign mem_re     = mem_read;
    assign alu_a_base = w_base;
    assign opcode     = r_ir[15:12];
    assign func       = r_ir[3:0];
    assign pc         = r_pc;
    assign sp         = r_sp;
    assign ir         = r_ir;
    assign mdr        = r_mdr;
    assign alu_out    = r_alu_out;
    assign stack_err  = r_stack_err;
    assign instr_cnt  = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_addr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_addr_unit
// Description : Table-driven directed bench for fetch_addr_unit, plus
//               hand-written reset and counter-wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_addr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_write, pc_write, pc_write_cond, sp_write, pc_mux;
    logic        mem_read, mem_write, alu_zero;
    logic [1:0]  pc_src, iord;
    logic [15:0] alu_result, store_data, mem_rdata;
    logic [15:0] mem_addr, mem_wdata, alu_a_base, pc, sp, ir, mdr, alu_out;
    logic        mem_we, mem_re, stack_err;
    logic [3:0]  opcode, func;
    logic [15:0] instr_cnt;

    fetch_addr_unit dut (
        .clk(clk), .rst(rst),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .sp_write(sp_write), .pc_mux(pc_mux), .mem_read(mem_read),
        .mem_write(mem_write), .pc_src(pc_src), .iord(iord),
        .alu_result(alu_result), .alu_zero(alu_zero), .store_data(store_data),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .alu_a_base(alu_a_base),
        .opcode(opcode), .func(func), .pc(pc), .sp(sp), .ir(ir), .mdr(mdr),
        .alu_out(alu_out), .stack_err(stack_err), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        irw, pcw, pcc, spw, pcm, mrd, mwr, zero;
        logic [1:0]  src, iord;
        logic [15:0] alu, rdata;
        // expected before the edge
        logic [15:0] e_addr, e_base;
        logic        e_we;
        // expected after the edge
        logic [15:0] e_pc, e_sp, e_ir, e_aout, e_mdr, e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t t;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        ir_write = 0; pc_write = 0; pc_write_cond = 0; sp_write = 0; pc_mux = 0;
        mem_read = 0; mem_write = 0; alu_zero = 0; pc_src = 2'd3; iord = 2'd0;
        alu_result = 16'h0000; mem_rdata = 16'h0000;
    endtask

    // Blank record: all strobes low, PC hold, expectations filled per row.
    function automatic vec_t blank();
        vec_t b;
        b.irw = 0; b.pcw = 0; b.pcc = 0; b.spw = 0; b.pcm = 0; b.mrd = 0; b.mwr = 0;
        b.zero = 0; b.src = 2'd3; b.iord = 2'd0; b.alu = 0; b.rdata = 0;
        b.e_addr = 0; b.e_base = 0; b.e_we = 0;
        b.e_pc = 0; b.e_sp = 16'hFFFF; b.e_ir = 0; b.e_aout = 0; b.e_mdr = 0;
        b.e_cnt = 0; b.e_err = 0;
        return b;
    endfunction

    initial begin
        // ---------------- vector table ----------------
        // fetch at 0000, PC <- 0001
        t = blank(); t.irw=1; t.pcw=1; t.src=0; t.mrd=1; t.alu=16'h0001; t.rdata=16'h1A05;
        t.e_addr=16'h0000; t.e_base=16'h0000; t.e_pc=16'h0001; t.e_ir=16'h1A05;
        t.e_aout=16'h0001; t.e_mdr=16'h1A05; t.e_cnt=1; vecs.push_back(t);
        // fetch at 0001, PC <- 3004
        t = blank(); t.irw=1; t.pcw=1; t.src=0; t.alu=16'h3004; t.rdata=16'hC123;
        t.e_addr=16'h0001; t.e_base=16'h0001; t.e_pc=16'h3004; t.e_ir=16'hC123;
        t.e_aout=16'h3004; t.e_mdr=16'h1A05; t.e_cnt=2; vecs.push_back(t);
        // jump: {3, 123}
        t = blank(); t.pcw=1; t.src=2; t.alu=16'h0040;
        t.e_addr=16'h3004; t.e_base=16'h3004; t.e_pc=16'h3123; t.e_ir=16'hC123;
        t.e_aout=16'h0040; t.e_mdr=16'h1A05; t.e_cnt=2; vecs.push_back(t);
        // pc_src=3 holds
        t = blank(); t.pcw=1; t.src=3; t.alu=16'h0040;
        t.e_addr=16'h3123; t.e_base=16'h3123; t.e_pc=16'h3123; t.e_ir=16'hC123;
        t.e_aout=16'h0040; t.e_mdr=16'h1A05; t.e_cnt=2; vecs.push_back(t);
        // conditional branch not taken
        t = blank(); t.pcc=1; t.src=1; t.zero=0; t.alu=16'h0040;
        t.e_addr=16'h3123; t.e_base=16'h3123; t.e_pc=16'h3123; t.e_ir=16'hC123;
        t.e_aout=16'h0040; t.e_mdr=16'h1A05; t.e_cnt=2; vecs.push_back(t);
        // conditional branch taken to ALUOut
        t = blank(); t.pcc=1; t.src=1; t.zero=1; t.alu=16'h0040;
        t.e_addr=16'h3123; t.e_base=16'h3123; t.e_pc=16'h0040; t.e_ir=16'hC123;
        t.e_aout=16'h0040; t.e_mdr=16'h1A05; t.e_cnt=2; vecs.push_back(t);
        // pc_write with pc_write_cond, zero=0: still loads once
        t = blank(); t.pcw=1; t.pcc=1; t.src=0; t.zero=0; t.alu=16'h0050;
        t.e_addr=16'h0040; t.e_base=16'h0040; t.e_pc=16'h0050; t.e_ir=16'hC123;
        t.e_aout=16'h0050; t.e_mdr=16'h1A05; t.e_cnt=2; vecs.push_back(t);
        // push SP update with pc_mux blocking pc_write
        t = blank(); t.pcm=1; t.spw=1; t.pcw=1; t.src=0; t.alu=16'hFFFE;
        t.e_addr=16'hFFFF; t.e_base=16'hFFFF; t.e_pc=16'h0050; t.e_sp=16'hFFFE;
        t.e_ir=16'hC123; t.e_aout=16'hFFFE; t.e_mdr=16'h1A05; t.e_cnt=2; vecs.push_back(t);
        // push write at SP
        t = blank(); t.pcm=1; t.iord=1; t.mwr=1; t.alu=16'h1111;
        t.e_addr=16'hFFFE; t.e_base=16'hFFFE; t.e_we=1; t.e_pc=16'h0050; t.e_sp=16'hFFFE;
        t.e_ir=16'hC123; t.e_aout=16'h1111; t.e_mdr=16'h1A05; t.e_cnt=2; vecs.push_back(t);
        // pop read at SP
        t = blank(); t.pcm=1; t.iord=0; t.mrd=1; t.rdata=16'hBEEF; t.alu=16'h2222;
        t.e_addr=16'hFFFE; t.e_base=16'hFFFE; t.e_pc=16'h0050; t.e_sp=16'hFFFE;
        t.e_ir=16'hC123; t.e_aout=16'h2222; t.e_mdr=16'hBEEF; t.e_cnt=2; vecs.push_back(t);
        // LW address from ALUOut, MDR holds without mem_read
        t = blank(); t.iord=2; t.alu=16'h3333; t.rdata=16'h5555;
        t.e_addr=16'h2222; t.e_base=16'h0050; t.e_pc=16'h0050; t.e_sp=16'hFFFE;
        t.e_ir=16'hC123; t.e_aout=16'h3333; t.e_mdr=16'hBEEF; t.e_cnt=2; vecs.push_back(t);
        // SP to lowest legal value, iord=3 also selects ALUOut
        t = blank(); t.iord=3; t.spw=1; t.alu=16'hFF00;
        t.e_addr=16'h3333; t.e_base=16'h0050; t.e_pc=16'h0050; t.e_sp=16'hFF00;
        t.e_ir=16'hC123; t.e_aout=16'hFF00; t.e_mdr=16'hBEEF; t.e_cnt=2; vecs.push_back(t);
        // illegal SP: holds, error set; same-cycle write still performed
        t = blank(); t.iord=1; t.spw=1; t.mwr=1; t.alu=16'hFEFF;
        t.e_addr=16'hFF00; t.e_base=16'h0050; t.e_we=1; t.e_pc=16'h0050; t.e_sp=16'hFF00;
        t.e_ir=16'hC123; t.e_aout=16'hFEFF; t.e_mdr=16'hBEEF; t.e_cnt=2; t.e_err=1;
        vecs.push_back(t);
        // subsequent write suppressed
        t = blank(); t.iord=1; t.mwr=1; t.alu=16'h0000;
        t.e_addr=16'hFF00; t.e_base=16'h0050; t.e_we=0; t.e_pc=16'h0050; t.e_sp=16'hFF00;
        t.e_ir=16'hC123; t.e_aout=16'h0000; t.e_mdr=16'hBEEF; t.e_cnt=2; t.e_err=1;
        vecs.push_back(t);

        // ---------------- reset state ----------------
        idle();
        store_data = 16'h1234;
        rst = 1'b1;
        #12;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_sp", sp, 16'hFFFF);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_mdr", mdr, 16'h0000);
        chk("rst_aout", alu_out, 16'h0000);
        chk("rst_err", {15'd0, stack_err}, 16'h0000);
        chk("rst_cnt", instr_cnt, 16'h0000);
        chk("rst_opc", {12'd0, opcode}, 16'h0000);
        chk("rst_func", {12'd0, func}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table loop ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            ir_write = vecs[i].irw; pc_write = vecs[i].pcw; pc_write_cond = vecs[i].pcc;
            sp_write = vecs[i].spw; pc_mux = vecs[i].pcm; mem_read = vecs[i].mrd;
            mem_write = vecs[i].mwr; alu_zero = vecs[i].zero; pc_src = vecs[i].src;
            iord = vecs[i].iord; alu_result = vecs[i].alu; mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_base", i), alu_a_base, vecs[i].e_base);
            chk($sformatf("v%0d_we", i), {15'd0, mem_we}, {15'd0, vecs[i].e_we});
            chk($sformatf("v%0d_re", i), {15'd0, mem_re}, {15'd0, vecs[i].mrd});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_sp", i), sp, vecs[i].e_sp);
            chk($sformatf("v%0d_ir", i), ir, vecs[i].e_ir);
            chk($sformatf("v%0d_opc", i), {12'd0, opcode}, {12'd0, vecs[i].e_ir[15:12]});
            chk($sformatf("v%0d_func", i), {12'd0, func}, {12'd0, vecs[i].e_ir[3:0]});
            chk($sformatf("v%0d_aout", i), alu_out, vecs[i].e_aout);
            chk($sformatf("v%0d_mdr", i), mdr, vecs[i].e_mdr);
            chk($sformatf("v%0d_cnt", i), instr_cnt, vecs[i].e_cnt);
            chk($sformatf("v%0d_err", i), {15'd0, stack_err}, {15'd0, vecs[i].e_err});
        end
        chk("wdata", mem_wdata, 16'h1234);

        // ---------------- reset clears sticky error ----------------
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        chk("err_clr", {15'd0, stack_err}, 16'h0000);
        chk("sp_clr", sp, 16'hFFFF);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- async reset mid-LW ----------------
        @(negedge clk);
        ir_write = 1; pc_write = 1; pc_src = 2'd0; mem_read = 1;
        alu_result = 16'h0123; mem_rdata = 16'h7777;
        @(posedge clk);
        #1;
        chk("lw_pc_pre", pc, 16'h0123);
        chk("lw_ir_pre", ir, 16'h7777);
        idle();
        iord = 2'd2;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc", pc, 16'h0000);
        chk("arst_ir", ir, 16'h0000);
        chk("arst_mdr", mdr, 16'h0000);
        chk("arst_cnt", instr_cnt, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        iord = 2'd0;
        #1;
        chk("arst_fetch", mem_addr, 16'h0000);

        // ---------------- instr_cnt wrap ----------------
        @(negedge clk);
        ir_write = 1; mem_rdata = 16'h0000;
        for (int k = 0; k < 65535; k++) @(posedge clk);
        #1;
        chk("cnt_ffff", instr_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        chk("cnt_wrap", instr_cnt, 16'h0000);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
